sdram_init_checker: RTL and testbench



---
 rtl/sdram_init_checker.sv | 206 ++++++++++++++++++++
 tb/tb_sdram_init_checker.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_checker.sv
// sdram_init_checker: passive monitor of the SDRAM power-up init sequence.
// Watches the command bus, enforces PRECHARGE-ALL -> AUTO_REFRESH x N ->
// LOAD_MODE ordering with minimum spacing, latches the mode register and
// reports completion or the first protocol violation (sticky).
module sdram_init_checker #(
    parameter int T_POWER  = 10000,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 7,
    parameter int T_MRD    = 3,
    parameter int AREF_NUM = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  cmd_in,
    input  logic [1:0]  ba_in,
    input  logic [12:0] addr_in,
    output logic        init_done,
    output logic [12:0] mode_reg,
    output logic [3:0]  aref_cnt,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int PW = $clog2(T_POWER + 1);

    // Sized copies of the timing parameters so every compare is width-matched
    localparam logic [PW-1:0] TPOW_L = PW'(T_POWER);
    localparam logic [3:0]    TRP_L  = 4'(T_RP);
    localparam logic [3:0]    TRFC_L = 4'(T_RFC);
    localparam logic [3:0]    TMRD_L = 4'(T_MRD);
    localparam logic [3:0]    AREF_L = 4'(AREF_NUM);

    typedef enum logic [2:0] {
        S_WAIT_PWR,
        S_TRP,
        S_AREF,
        S_TMRD,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_PRE,
        CMD_AREF,
        CMD_LMR,
        CMD_OTHER
    } cmd_t;

    state_t         r_state;
    logic [2:0]     r_err_code;
    logic [3:0]     r_aref;
    logic [12:0]    r_mode;
    logic           r_done;
    logic [PW-1:0]  r_pwr_cnt;
    logic [3:0]     r_dist;

    state_t         w_state_next;
    logic [2:0]     w_err_code_next;
    logic [3:0]     w_aref_next;
    logic [12:0]    w_mode_next;
    logic           w_done_next;
    logic           w_accept;
    cmd_t           w_cmd;
    logic           w_is_nop;

    // Decode the {cs_n,ras_n,cas_n,we_n} command word
    always_comb begin
        w_cmd = CMD_OTHER;
        if (cmd_in[3] || cmd_in == 4'b0111) begin
            w_cmd = CMD_NOP;
        end else begin
            case (cmd_in)
                4'b0010: w_cmd = CMD_PRE;
                4'b0001: w_cmd = CMD_AREF;
                4'b0000: w_cmd = CMD_LMR;
                default: w_cmd = CMD_OTHER;
            endcase
        end
    end

    assign w_is_nop = (w_cmd == CMD_NOP);

    // Power-up counter: saturates at T_POWER, restarts on every reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pwr_cnt <= '0;
        end else if (r_pwr_cnt != TPOW_L) begin
            r_pwr_cnt <= r_pwr_cnt + PW'(1);
        end
    end

    // Distance since last accepted command: 1 on the cycle after acceptance
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dist <= 4'd0;
        end else if (w_accept) begin
            r_dist <= 4'd1;
        end else if (r_dist != 4'd15) begin
            r_dist <= r_dist + 4'd1;
        end
    end

    // FSM state and sticky output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_WAIT_PWR;
            r_err_code <= 3'd0;
            r_aref     <= 4'd0;
            r_mode     <= 13'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_err_code <= w_err_code_next;
            r_aref     <= w_aref_next;
            r_mode     <= w_mode_next;
            r_done     <= w_done_next;
        end
    end

    // Next-state and checks; within one command the earlier test wins,
    // giving early > order > address-field > spacing priority
    always_comb begin
        w_state_next    = r_state;
        w_err_code_next = r_err_code;
        w_aref_next     = r_aref;
        w_mode_next     = r_mode;
        w_done_next     = r_done;
        w_accept        = 1'b0;
        case (r_state)
            S_WAIT_PWR: begin
                if (!w_is_nop) begin
                    if (r_pwr_cnt < TPOW_L) begin
                        w_state_next = S_ERROR; w_err_code_next = 3'd1;
                    end else if (w_cmd == CMD_PRE) begin
                        if (addr_in[10]) begin
                            w_state_next = S_TRP;
                            w_accept     = 1'b1;
                        end else begin
                            w_state_next = S_ERROR; w_err_code_next = 3'd6;
                        end
                    end else begin
                        w_state_next = S_ERROR; w_err_code_next = 3'd2;
                    end
                end
            end
            S_TRP: begin
                if (!w_is_nop) begin
                    if (w_cmd != CMD_AREF) begin
                        w_state_next = S_ERROR; w_err_code_next = 3'd2;
                    end else if (r_dist < TRP_L) begin
                        w_state_next = S_ERROR; w_err_code_next = 3'd3;
                    end else begin
                        w_aref_next  = 4'd1;
                        w_state_next = S_AREF;
                        w_accept     = 1'b1;
                    end
                end
            end
            S_AREF: begin
                if (!w_is_nop) begin
                    if (r_aref < AREF_L) begin
                        if (w_cmd != CMD_AREF) begin
                            w_state_next = S_ERROR; w_err_code_next = 3'd2;
                        end else if (r_dist < TRFC_L) begin
                            w_state_next = S_ERROR; w_err_code_next = 3'd4;
                        end else begin
                            w_aref_next = r_aref + 4'd1;
                            w_accept    = 1'b1;
                        end
                    end else begin
                        if (w_cmd != CMD_LMR) begin
                            w_state_next = S_ERROR; w_err_code_next = 3'd2;
                        end else if (ba_in != 2'b00 || addr_in[12:10] != 3'b000) begin
                            w_state_next = S_ERROR; w_err_code_next = 3'd7;
                        end else if (r_dist < TRFC_L) begin
                            w_state_next = S_ERROR; w_err_code_next = 3'd4;
                        end else begin
                            w_mode_next  = addr_in;
                            w_state_next = S_TMRD;
                            w_accept     = 1'b1;
                        end
                    end
                end
            end
            S_TMRD: begin
                if (!w_is_nop) begin
                    w_state_next = S_ERROR; w_err_code_next = 3'd5;
                end else if (r_dist >= TMRD_L) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            default: begin
                // DONE and ERROR hold everything
            end
        endcase
    end

    assign init_done = r_done;
    assign mode_reg  = r_mode;
    assign aref_cnt  = r_aref;
    assign err       = (r_state == S_ERROR);
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Directed bench for sdram_init_checker. u_dut uses the default timing
// (full 10000-cycle power-up); u_fast shares the same bus with a short
// power-up window so the many error scenarios stay cheap to simulate.
module tb_sdram_init_checker;

    localparam int FP = 100;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;
    localparam logic [3:0] ACT  = 4'b0011;

    logic        clk;
    logic        rst_n;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;

    logic        d_init_done, f_init_done;
    logic [12:0] d_mode_reg,  f_mode_reg;
    logic [3:0]  d_aref_cnt,  f_aref_cnt;
    logic        d_err,       f_err;
    logic [2:0]  d_err_code,  f_err_code;

    int checks;
    int passes;

    sdram_init_checker u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .cmd_in    (cmd),
        .ba_in     (ba),
        .addr_in   (addr),
        .init_done (d_init_done),
        .mode_reg  (d_mode_reg),
        .aref_cnt  (d_aref_cnt),
        .err       (d_err),
        .err_code  (d_err_code)
    );

    sdram_init_checker #(.T_POWER(FP)) u_fast (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .cmd_in    (cmd),
        .ba_in     (ba),
        .addr_in   (addr),
        .init_done (f_init_done),
        .mode_reg  (f_mode_reg),
        .aref_cnt  (f_aref_cnt),
        .err       (f_err),
        .err_code  (f_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // One command cycle; outputs are sampled 1 ns after the edge
    task automatic step(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b);
        cmd = c; addr = a; ba = b;
        @(posedge clk);
        #1;
        if (c != NOP) $display("t=%0t cmd=%b ba=%0d addr=%h", $time, c, b, a);
        cmd = NOP; addr = 13'd0; ba = 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(NOP, 13'd0, 2'd0);
    endtask

    // PRECHARGE-ALL after `pwr` NOP edges, then n legally spaced refreshes
    task automatic legal_prefix(input int pwr, input int n);
        idle(pwr);
        step(PRE, 13'h400, 2'd0);
        if (n > 0) begin
            idle(1);
            step(AREF, 13'd0, 2'd0);
            for (int i = 1; i < n; i++) begin
                idle(6);
                step(AREF, 13'd0, 2'd0);
            end
        end
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any edge
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d_init_done, d_mode_reg, d_aref_cnt, d_err, d_err_code} !== 22'd0)
            $display("FAIL async_reset_dut: got %h want 0",
                     {d_init_done, d_mode_reg, d_aref_cnt, d_err, d_err_code});
        else passes++;
        checks++;
        if ({f_init_done, f_mode_reg, f_aref_cnt, f_err, f_err_code} !== 22'd0)
            $display("FAIL async_reset_fast: got %h want 0",
                     {f_init_done, f_mode_reg, f_aref_cnt, f_err, f_err_code});
        else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({d_init_done, d_mode_reg, d_aref_cnt, d_err, d_err_code} !== 22'd0)
            $display("FAIL reset_values: got %h want 0",
                     {d_init_done, d_mode_reg, d_aref_cnt, d_err, d_err_code});
        else passes++;
    endtask

    task automatic test_legal();
        legal_prefix(10000, 8);
        checks++;
        if (d_aref_cnt !== 4'd8) $display("FAIL legal_aref8: got %0d want 8", d_aref_cnt);
        else passes++;
        idle(6);
        step(LMR, 13'h032, 2'd0);
        checks++;
        if (d_init_done !== 1'b0) $display("FAIL legal_done_l0: got %b want 0", d_init_done);
        else passes++;
        step(4'b1000, 13'h000, 2'd0);   // cs_n high: a NOP inside tMRD
        checks++;
        if (d_init_done !== 1'b0) $display("FAIL legal_done_l1: got %b want 0", d_init_done);
        else passes++;
        idle(1);
        checks++;
        if (d_init_done !== 1'b0 || d_err !== 1'b0)
            $display("FAIL legal_done_l2: got done=%b err=%b want 0 0", d_init_done, d_err);
        else passes++;
        idle(1);
        checks++;
        if (d_init_done !== 1'b1) $display("FAIL legal_done_l3: got %b want 1", d_init_done);
        else passes++;
        checks++;
        if (d_mode_reg !== 13'h032 || d_aref_cnt !== 4'd8 || d_err !== 1'b0)
            $display("FAIL legal_outputs: got mode=%h aref=%0d err=%b want 032 8 0",
                     d_mode_reg, d_aref_cnt, d_err);
        else passes++;
        step(PRE, 13'h000, 2'd0);       // ignored once done
        checks++;
        if (d_init_done !== 1'b1 || d_err !== 1'b0 || d_mode_reg !== 13'h032)
            $display("FAIL done_holds: got done=%b err=%b mode=%h want 1 0 032",
                     d_init_done, d_err, d_mode_reg);
        else passes++;
    endtask

    task automatic test_early();
        apply_reset();
        idle(499);
        checks++;
        if (d_err !== 1'b0) $display("FAIL early_pre_before: got err=%b want 0", d_err);
        else passes++;
        step(PRE, 13'h400, 2'd0);       // edge 500
        checks++;
        if (d_err !== 1'b1 || d_err_code !== 3'd1)
            $display("FAIL early_code1: got err=%b code=%0d want 1 1", d_err, d_err_code);
        else passes++;
        legal_prefix(9500, 8);
        idle(6);
        step(LMR, 13'h032, 2'd0);
        idle(3);
        checks++;
        if (d_err !== 1'b1 || d_err_code !== 3'd1 || d_init_done !== 1'b0 ||
            d_aref_cnt !== 4'd0 || d_mode_reg !== 13'd0)
            $display("FAIL early_sticky: got err=%b code=%0d done=%b aref=%0d mode=%h want 1 1 0 0 000",
                     d_err, d_err_code, d_init_done, d_aref_cnt, d_mode_reg);
        else passes++;
    endtask

    task automatic test_priority();
        apply_reset();
        idle(10);
        step(AREF, 13'd0, 2'd0);        // early and out of order
        checks++;
        if (f_err_code !== 3'd1) $display("FAIL prio_early_over_order: got %0d want 1", f_err_code);
        else passes++;
        apply_reset();
        idle(FP);
        step(ACT, 13'h400, 2'd0);
        checks++;
        if (f_err_code !== 3'd2) $display("FAIL order_other_first: got %0d want 2", f_err_code);
        else passes++;
        step(PRE, 13'h000, 2'd0);       // later error must not overwrite
        checks++;
        if (f_err !== 1'b1 || f_err_code !== 3'd2)
            $display("FAIL sticky_first: got err=%b code=%0d want 1 2", f_err, f_err_code);
        else passes++;
    endtask

    task automatic test_a10();
        apply_reset();
        idle(FP);
        step(PRE, 13'h000, 2'd0);
        checks++;
        if (f_err !== 1'b1 || f_err_code !== 3'd6)
            $display("FAIL pre_a10_low: got err=%b code=%0d want 1 6", f_err, f_err_code);
        else passes++;
    endtask

    task automatic test_lmr_ba();
        apply_reset();
        legal_prefix(FP, 8);
        idle(6);
        step(LMR, 13'h032, 2'd1);
        checks++;
        if (f_err_code !== 3'd7 || f_mode_reg !== 13'd0 || f_init_done !== 1'b0)
            $display("FAIL lmr_ba1: got code=%0d mode=%h done=%b want 7 000 0",
                     f_err_code, f_mode_reg, f_init_done);
        else passes++;
    endtask

    task automatic test_short_aref();
        apply_reset();
        legal_prefix(FP, 7);
        idle(6);
        step(LMR, 13'h032, 2'd0);
        checks++;
        if (f_err_code !== 3'd2 || f_aref_cnt !== 4'd7)
            $display("FAIL aref7_then_lmr: got code=%0d aref=%0d want 2 7", f_err_code, f_aref_cnt);
        else passes++;
    endtask

    task automatic test_aref_spacing();
        apply_reset();
        legal_prefix(FP, 2);
        idle(5);
        step(AREF, 13'd0, 2'd0);        // spaced 6
        checks++;
        if (f_err_code !== 3'd4 || f_aref_cnt !== 4'd2)
            $display("FAIL trfc_short: got code=%0d aref=%0d want 4 2", f_err_code, f_aref_cnt);
        else passes++;
    endtask

    task automatic test_trp();
        apply_reset();
        idle(FP);
        step(PRE, 13'h400, 2'd0);
        step(AREF, 13'd0, 2'd0);        // spaced 1
        checks++;
        if (f_err_code !== 3'd3 || f_aref_cnt !== 4'd0)
            $display("FAIL trp_short: got code=%0d aref=%0d want 3 0", f_err_code, f_aref_cnt);
        else passes++;
    endtask

    task automatic test_tmrd();
        apply_reset();
        legal_prefix(FP, 8);
        idle(6);
        step(LMR, 13'h032, 2'd0);
        step(AREF, 13'd0, 2'd0);
        checks++;
        if (f_err_code !== 3'd5 || f_mode_reg !== 13'h032)
            $display("FAIL tmrd_violation: got code=%0d mode=%h want 5 032", f_err_code, f_mode_reg);
        else passes++;
        idle(5);
        checks++;
        if (f_init_done !== 1'b0 || f_err !== 1'b1)
            $display("FAIL tmrd_no_done: got done=%b err=%b want 0 1", f_init_done, f_err);
        else passes++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        legal_prefix(10000, 4);
        checks++;
        if (d_aref_cnt !== 4'd4) $display("FAIL mid_aref4: got %0d want 4", d_aref_cnt);
        else passes++;
        apply_reset();
        legal_prefix(10000, 8);
        idle(6);
        step(LMR, 13'h032, 2'd0);
        idle(3);
        checks++;
        if (d_init_done !== 1'b1 || d_err !== 1'b0 || d_mode_reg !== 13'h032 || d_aref_cnt !== 4'd8)
            $display("FAIL mid_reset_relegal: got done=%b err=%b mode=%h aref=%0d want 1 0 032 8",
                     d_init_done, d_err, d_mode_reg, d_aref_cnt);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        cmd    = NOP;
        ba     = 2'd0;
        addr   = 13'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_legal();
        test_early();
        test_priority();
        test_a10();
        test_lmr_ba();
        test_short_aref();
        test_aref_spacing();
        test_trp();
        test_tmrd();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
